rgb_out_packer: RTL
===================

// Module: rgb_out_packer
// PURPOSE
//  Output stage placed directly after the gamma stage. Gamma emits one colour component per cycle, in R,G,B order.
//  This block gathers the three components of each pixel into one RGB word.
//  Packed words are buffered in a FIFO and leave on a valid/ready interface towards the host/DMA.
//  Upstream has no backpressure, so overflow and sequence faults are flagged, never stalled.
// PARAMETERS
//  FIFO_DEPTH  16  packed-word FIFO entries; power of two, >=2
//  CNT_W       24  width of the pixel/frame counters (stats option only)
// PORTS
//  clk           in   1                 clock, all logic on rising edge
//  rst           in   1                 asynchronous reset, active-high
//  pixel_in      in   `COLOR_DEPTH      colour component from gamma
//  valid_in      in   1                 pixel_in/color_in qualifier
//  color_in      in   `COLOR_BIT_CNT    RED/GREEN/BLUE/VOID tag
//  last_col_in   in   1                 last column of line (meaningful on BLUE)
//  last_pic_in   in   1                 last pixel of frame (meaningful on BLUE)
//  err_clr       in   1                 clears seq_err and ovf_err
//  rgb_out       out  3*`COLOR_DEPTH    {R,G,B}, R in MSBs
//  rgb_valid     out  1                 rgb_out valid
//  rgb_ready     in   1                 sink accepts when rgb_valid&&rgb_ready
//  last_col_out  out  1                 word closes a line
//  last_pic_out  out  1                 word closes a frame
//  seq_err       out  1                 sticky: colour order violated
//  ovf_err       out  1                 sticky: packed word dropped, FIFO full
//  pix_cnt       out  CNT_W             stats option only
//  frame_cnt     out  CNT_W             stats option only
// BEHAVIOUR
//  - Reset: FSM=S_R, FIFO empty, rgb_valid=0, rgb_out=0, last_*_out=0, seq_err=ovf_err=0, counters=0.
//  - FSM (advances only on valid_in; VOID with valid_in is ignored, state held):
//    S_R: RED  -> capture r, S_G; GREEN/BLUE -> seq_err=1, stay S_R.
//    S_G: GREEN-> capture g, S_B; RED -> seq_err=1, capture r, S_G; BLUE -> seq_err=1, S_R.
//    S_B: BLUE -> push {r,g,pixel_in,last_col_in,last_pic_in}, S_R;
//         RED  -> seq_err=1, capture r, S_G; GREEN -> seq_err=1, S_R.
//  - last_col_in/last_pic_in are sampled only with the BLUE component. They are ignored on other components.
//  - Latency: BLUE accepted at cycle N -> word in FIFO at N+1. With the FIFO empty, rgb_valid=1 at N+1 (registered first-word-fall-through).
//  - Handshake: rgb_out and last_*_out stay stable while rgb_valid && !rgb_ready. They update only after a pop.
//  - Push accepted when !full, or when full with a pop in the same cycle. Full with no pop: the word is dropped and ovf_err=1.
//  - Pop with push in the same cycle while the FIFO is empty cannot occur (rgb_valid=0), so there is no bypass path.
//  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty come from comparing the MSB.
//  - err_clr has priority over a same-cycle error set: the flag reads 0 on the next cycle. The event is lost and is not re-flagged.
//  - Asserting rst mid-frame discards any partial pixel and all FIFO contents immediately.
// CONFIGURATION
//  - `RGB_PACKER_STATS_EN defined:
//    pix_cnt increments on every popped word and clears on the cycle after a pop with last_pic_out=1.
//    frame_cnt increments on that same pop and wraps at 2^CNT_W.
//  - Not defined: pix_cnt/frame_cnt ports are absent and no counter logic is built.
// STRUCTURE
//  - Shared isp_pkg holds COLOR_DEPTH, COLOR_BIT_CNT, the RED/GREEN/BLUE/VOID codes and an rgb_word_t typedef {r,g,b,last_col,last_pic}.
//  - Sub-module rgb_sync_fifo: single-clock FIFO parameterised by width/depth. Outputs full, empty and registered head data.
//  - Top level holds the FSM, the r/g capture registers, the error flags and the optional stats.
// TESTING
//  1 R=0x10,G=0x20,B=0x30 back-to-back, rgb_ready=1 -> rgb_out=0x102030 one cycle after B, last_*_out=0.
//  2 4 pixels with last_col_in=1 on the 4th B and last_pic_in=1 on the 4th B -> only word 4 has last_col_out=last_pic_out=1.
//    With STATS_EN: frame_cnt=1 and pix_cnt=0 afterwards.
//  3 R,B,G,B sequence -> seq_err=1, no word emitted. Then R,G,B -> one correct word. err_clr pulse -> seq_err=0.
//  4 rgb_ready=0, 17 pixels, FIFO_DEPTH=16 -> 16 words held, ovf_err=1.
//    Raise ready -> first 16 pixels drain in order, one per cycle.
//  5 FIFO full, ready=1 with a BLUE push in the same cycle -> no drop, ovf_err stays 0, count stays 16.
//  6 rst pulse after R,G of a pixel with 3 words queued -> rgb_valid=0 immediately.
//    Next R,G,B -> a single new word.

Source files
------------

// File: rtl/isp_pkg.sv
// rtl/isp_pkg.sv - shared ISP pixel constants and the packed RGB word type
//
// Purpose : colour depth, colour tag codes and the rgb_word_t record passed
//           from the RGB packer into its output FIFO.
// Ports   : none (package)

package isp_pkg;

  localparam int COLOR_DEPTH   = 8;
  localparam int COLOR_BIT_CNT = 2;

  // Colour tag carried alongside each gamma component
  localparam logic [COLOR_BIT_CNT-1:0] COLOR_VOID  = 2'd0;
  localparam logic [COLOR_BIT_CNT-1:0] COLOR_RED   = 2'd1;
  localparam logic [COLOR_BIT_CNT-1:0] COLOR_GREEN = 2'd2;
  localparam logic [COLOR_BIT_CNT-1:0] COLOR_BLUE  = 2'd3;

  typedef struct packed {
    logic [COLOR_DEPTH-1:0] r;
    logic [COLOR_DEPTH-1:0] g;
    logic [COLOR_DEPTH-1:0] b;
    logic                   last_col;
    logic                   last_pic;
  } rgb_word_t;

endpackage

// File: rtl/rgb_sync_fifo.sv
// rtl/rgb_sync_fifo.sv - single-clock FIFO with registered first-word-fall-through head
//
// Purpose : buffers packed words; the head entry is held in a register so it
//           is stable while the sink stalls.
// Ports   : clk, rst (async, active-high)
//           push, push_data  - write side; ignored when full unless popping
//           pop              - read side; consumes head_data when !empty
//           head_data        - current head entry (valid when !empty)
//           full, empty      - occupancy flags

module rgb_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_ptr_nxt;
  logic             wr_en;
  logic             rd_en;
  logic             head_load;
  logic [WIDTH-1:0] head_nxt;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full FIFO can still take a word when the head leaves in the same cycle
  assign wr_en      = push && (!full || pop);
  assign rd_en      = pop && !empty;
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, rd_en};

  // Head reloads when it is consumed, or when the first word lands in an
  // empty FIFO. If the next head is being written right now, take it from
  // the write port instead of the (not yet updated) memory.
  always_comb begin
    head_nxt  = mem[rd_ptr_nxt[AW-1:0]];
    head_load = 1'b0;
    if (wr_en && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]))
      head_nxt = push_data;
    if (rd_en && (wr_en || (rd_ptr_nxt != wr_ptr)))
      head_load = 1'b1;
    else if (empty && wr_en)
      head_load = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      head_data <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      if (head_load)
        head_data <= head_nxt;
    end
  end

endmodule

// File: rtl/rgb_out_packer.sv
// rtl/rgb_out_packer.sv - packs R,G,B gamma components into RGB words behind a valid/ready FIFO
//
// Purpose : collects one colour component per cycle (R,G,B order) into a
//           packed {R,G,B} word, queues it and presents it to the host/DMA.
//           Order violations and FIFO overflow raise sticky flags; nothing
//           is ever stalled upstream.
// Ports   : clk, rst (async, active-high)
//           pixel_in, valid_in, color_in     - component stream from gamma
//           last_col_in, last_pic_in         - end markers, taken with BLUE
//           err_clr                          - clears seq_err / ovf_err
//           rgb_out, rgb_valid, rgb_ready    - packed word handshake
//           last_col_out, last_pic_out       - end markers of the head word
//           seq_err, ovf_err                 - sticky fault flags
//           pix_cnt, frame_cnt               - only with RGB_PACKER_STATS_EN
// Config  : define RGB_PACKER_STATS_EN to build the pixel/frame counters.

module rgb_out_packer
  import isp_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COLOR_DEPTH-1:0]     pixel_in,
  input  logic                       valid_in,
  input  logic [COLOR_BIT_CNT-1:0]   color_in,
  input  logic                       last_col_in,
  input  logic                       last_pic_in,
  input  logic                       err_clr,
  output logic [3*COLOR_DEPTH-1:0]   rgb_out,
  output logic                       rgb_valid,
  input  logic                       rgb_ready,
  output logic                       last_col_out,
  output logic                       last_pic_out,
  output logic                       seq_err,
  output logic                       ovf_err
`ifdef RGB_PACKER_STATS_EN
  ,
  output logic [CNT_W-1:0]           pix_cnt,
  output logic [CNT_W-1:0]           frame_cnt
`endif
);

  typedef enum logic [1:0] {S_R, S_G, S_B} state_e;

  state_e                 state;
  logic [COLOR_DEPTH-1:0] r_q;
  logic [COLOR_DEPTH-1:0] g_q;
  logic                   push;
  logic                   pop;
  logic                   seq_set;
  logic                   ovf_set;
  logic                   fifo_full;
  logic                   fifo_empty;
  rgb_word_t              push_word;
  rgb_word_t              head_word;

  wire is_red   = valid_in && (color_in == COLOR_RED);
  wire is_green = valid_in && (color_in == COLOR_GREEN);
  wire is_blue  = valid_in && (color_in == COLOR_BLUE);

  // Push straight from the BLUE cycle so the word is in the FIFO one clock later
  assign push      = is_blue && (state == S_B);
  assign push_word = '{r: r_q, g: g_q, b: pixel_in,
                       last_col: last_col_in, last_pic: last_pic_in};
  assign pop       = rgb_valid && rgb_ready;
  assign ovf_set   = push && fifo_full && !pop;

  // Any valid non-VOID component that is not the expected one is an order fault
  always_comb begin
    seq_set = 1'b0;
    case (state)
      S_R:     seq_set = is_green || is_blue;
      S_G:     seq_set = is_red   || is_blue;
      S_B:     seq_set = is_red   || is_green;
      default: seq_set = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_R;
      r_q     <= '0;
      g_q     <= '0;
      seq_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      // A stray RED always restarts a pixel; other faults fall back to S_R
      case (state)
        S_R: begin
          if (is_red) begin
            r_q   <= pixel_in;
            state <= S_G;
          end
        end
        S_G: begin
          if (is_red) begin
            r_q   <= pixel_in;
            state <= S_G;
          end else if (is_green) begin
            g_q   <= pixel_in;
            state <= S_B;
          end else if (is_blue) begin
            state <= S_R;
          end
        end
        S_B: begin
          if (is_red) begin
            r_q   <= pixel_in;
            state <= S_G;
          end else if (is_green || is_blue) begin
            state <= S_R;
          end
        end
        default: state <= S_R;
      endcase

      // Clear wins over a coincident set; that event is not re-flagged
      if (err_clr)
        seq_err <= 1'b0;
      else if (seq_set)
        seq_err <= 1'b1;

      if (err_clr)
        ovf_err <= 1'b0;
      else if (ovf_set)
        ovf_err <= 1'b1;
    end
  end

  rgb_sync_fifo #(
    .WIDTH ($bits(rgb_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head_data (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rgb_valid    = !fifo_empty;
  assign rgb_out      = {head_word.r, head_word.g, head_word.b};
  assign last_col_out = head_word.last_col;
  assign last_pic_out = head_word.last_pic;

`ifdef RGB_PACKER_STATS_EN
  // pix_cnt counts words within the current frame; the closing word resets it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt   <= '0;
      frame_cnt <= '0;
    end else if (pop) begin
      if (last_pic_out) begin
        pix_cnt   <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end else begin
        pix_cnt   <= pix_cnt + 1'b1;
      end
    end
  end
`else
  // Counters are not built in this configuration
`endif

endmodule
